// File: rtl/date_time_setter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | date_time_setter: button-driven year/month/day/hour/minute editor that    |
// | snapshots the running clock and commits edits with a one-cycle load.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module date_time_setter #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int TO_W           = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_day,
   input  logic [5:0] cur_mon,
   input  logic [6:0] cur_year,
   output logic       set_active,
   output logic [2:0] field_sel,
   output logic       load,
   output logic [5:0] set_sec,
   output logic [5:0] set_min,
   output logic [5:0] set_hour,
   output logic [5:0] set_day,
   output logic [5:0] set_mon,
   output logic [6:0] set_year
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_YEAR = 3'd1,
      S_MON  = 3'd2,
      S_DAY  = 3'd3,
      S_HOUR = 3'd4,
      S_MIN  = 3'd5,
      COMMIT = 3'd6
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   function automatic logic [5:0] days_in_month(input logic [5:0] mon, input logic leap);
      case (mon)
         6'd2:                    days_in_month = leap ? 6'd29 : 6'd28;
         6'd4, 6'd6, 6'd9, 6'd11: days_in_month = 6'd30;
         default:                 days_in_month = 6'd31;
      endcase
   endfunction

   state_t          state;
   logic [TO_W-1:0] to_cnt;

   // Button synchronizers; bit 2 = mode, bit 1 = up, bit 0 = down
   logic [2:0] sync_q [SYNC_STAGES];
   logic [2:0] prev_q;
   logic [2:0] ev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 3'b000;
         prev_q <= 3'b000;
         ev_q   <= 3'b000;
      end else begin
         sync_q[0] <= {btn_mode, btn_up, btn_down};
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= sync_q[SYNC_STAGES-1];
         ev_q   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   logic ev_mode, ev_up, ev_down, any_ev, step_up, step_dn, step;
   assign ev_mode = ev_q[2];
   assign ev_up   = ev_q[1];
   assign ev_down = ev_q[0];
   assign any_ev  = |ev_q;
   assign step_up = ev_up & ~ev_down;
   assign step_dn = ev_down & ~ev_up;
   assign step    = step_up | step_dn;

   assign set_sec = 6'd0;

   logic [6:0] year_step, snap_year;
   logic [5:0] mon_step, day_step, hour_step, min_step;
   logic [5:0] dim_cur, dim_ys, dim_ms;
   logic [5:0] snap_mon, snap_dim, snap_day, snap_hour, snap_min;

   always_comb begin
      if (step_up) begin
         year_step = (set_year >= 7'd99) ? 7'd0 : set_year + 7'd1;
         mon_step  = (set_mon  >= 6'd12) ? 6'd1 : set_mon  + 6'd1;
         hour_step = (set_hour >= 6'd23) ? 6'd0 : set_hour + 6'd1;
         min_step  = (set_min  >= 6'd59) ? 6'd0 : set_min  + 6'd1;
      end else begin
         year_step = (set_year == 7'd0) ? 7'd99 : set_year - 7'd1;
         mon_step  = (set_mon  <= 6'd1) ? 6'd12 : set_mon  - 6'd1;
         hour_step = (set_hour == 6'd0) ? 6'd23 : set_hour - 6'd1;
         min_step  = (set_min  == 6'd0) ? 6'd59 : set_min  - 6'd1;
      end

      dim_cur = days_in_month(set_mon, set_year[1:0] == 2'b00);
      if (step_up) day_step = (set_day >= dim_cur) ? 6'd1 : set_day + 6'd1;
      else         day_step = (set_day <= 6'd1) ? dim_cur : set_day - 6'd1;

      // Month-length after a year or month step, used to clamp the day
      dim_ys = days_in_month(set_mon, year_step[1:0] == 2'b00);
      dim_ms = days_in_month(mon_step, set_year[1:0] == 2'b00);

      snap_year = (cur_year > 7'd99) ? 7'd99 : cur_year;
      snap_mon  = (cur_mon == 6'd0) ? 6'd1 : ((cur_mon > 6'd12) ? 6'd12 : cur_mon);
      snap_dim  = days_in_month(snap_mon, snap_year[1:0] == 2'b00);
      snap_day  = (cur_day == 6'd0) ? 6'd1 : ((cur_day > snap_dim) ? snap_dim : cur_day);
      snap_hour = (cur_hour > 6'd23) ? 6'd23 : cur_hour;
      snap_min  = (cur_min  > 6'd59) ? 6'd59 : cur_min;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         set_active <= 1'b0;
         field_sel  <= 3'd0;
         load       <= 1'b0;
         to_cnt     <= '0;
         set_min    <= 6'd0;
         set_hour   <= 6'd0;
         set_day    <= 6'd1;
         set_mon    <= 6'd1;
         set_year   <= 7'd0;
      end else begin
         load <= 1'b0;
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (ev_mode) begin
                  set_year   <= snap_year;
                  set_mon    <= snap_mon;
                  set_day    <= snap_day;
                  set_hour   <= snap_hour;
                  set_min    <= snap_min;
                  state      <= S_YEAR;
                  set_active <= 1'b1;
                  field_sel  <= 3'd1;
               end
            end
            S_YEAR, S_MON, S_DAY, S_HOUR, S_MIN: begin
               if (any_ev) to_cnt <= '0;
               else        to_cnt <= to_cnt + TO_W'(1);

               if (ev_mode) begin
                  if (state == S_MIN) begin
                     state     <= COMMIT;
                     load      <= 1'b1;
                     field_sel <= 3'd0;
                  end else begin
                     state     <= state_t'(state + 3'd1);
                     field_sel <= field_sel + 3'd1;
                  end
               end else if (!any_ev && to_cnt == TO_LAST) begin
                  // Abandoned edit: drop back without committing
                  state      <= IDLE;
                  set_active <= 1'b0;
                  field_sel  <= 3'd0;
                  to_cnt     <= '0;
               end else if (step) begin
                  case (state)
                     S_YEAR: begin
                        set_year <= year_step;
                        if (set_day > dim_ys) set_day <= dim_ys;
                     end
                     S_MON: begin
                        set_mon <= mon_step;
                        if (set_day > dim_ms) set_day <= dim_ms;
                     end
                     S_DAY:   set_day  <= day_step;
                     S_HOUR:  set_hour <= hour_step;
                     S_MIN:   set_min  <= min_step;
                     default: ;
                  endcase
               end
            end
            COMMIT: begin
               state      <= IDLE;
               set_active <= 1'b0;
               field_sel  <= 3'd0;
               to_cnt     <= '0;
            end
            default: begin
               state      <= IDLE;
               set_active <= 1'b0;
               field_sel  <= 3'd0;
               to_cnt     <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/date_time_setter.md
Name: date_time_setter

Overview:
- User-facing set controller for the century clock; the write side of the time/date counter chain.
- Snapshots the running counter values, lets the user step through year, month, day, hour and minute with three buttons, and wraps each field within its legal range.
- Issues a single-cycle load pulse with the new values for the counters to take.
- Runs on the fast system clock, not on the 1 Hz tick.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each button input before edge detection.
- TIMEOUT_CYCLES, 50_000_000, idle cycles in a SET state before abort (no load).
- TO_W, 26, width of the timeout counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- btn_mode  input  1  debounced level; rising edge advances to the next field
- btn_up  input  1  debounced level; rising edge increments the current field
- btn_down  input  1  debounced level; rising edge decrements the current field
- cur_min  input  6  running minute, 0..59
- cur_hour  input  6  running hour, 0..23
- cur_day  input  6  running day, 1..31
- cur_mon  input  6  running month, 1..12
- cur_year  input  7  running year within century, 0..99
- set_active  output  1  high in any SET state; counters must hold
- field_sel  output  3  0 idle, 1 year, 2 mon, 3 day, 4 hour, 5 min
- load  output  1  one-cycle commit pulse
- set_sec  output  6  always 0
- set_min  output  6  edited minute
- set_hour  output  6  edited hour
- set_day  output  6  edited day
- set_mon  output  6  edited month
- set_year  output  7  edited year

Behaviour:
- Reset (async, rst=1) forces:
  - State IDLE, set_active=0, field_sel=0, load=0, timeout counter 0.
  - set_min=0, set_hour=0, set_day=1, set_mon=1, set_year=0, set_sec=0.
- Inputs pass through SYNC_STAGES flops and are then rising-edge detected. An edge event is one cycle wide. Event latency is SYNC_STAGES+1 cycles after the input rises.
- FSM states: IDLE, S_YEAR, S_MON, S_DAY, S_HOUR, S_MIN, COMMIT.
  - IDLE + mode event: copy cur_* into set_* and go to S_YEAR.
  - S_YEAR -> S_MON -> S_DAY -> S_HOUR -> S_MIN on each mode event.
  - S_MIN + mode event: go to COMMIT.
  - COMMIT: assert load=1 for exactly one cycle, then return to IDLE. load falls in the IDLE cycle.
- set_active is 1 in S_YEAR..S_MIN and in COMMIT. field_sel follows the state encoding above; it is 0 in COMMIT.
- Up/down applies only to the current field, taking effect the cycle after the event.
  - Up and down events in the same cycle: ignored.
  - Mode event together with up or down: mode wins and up/down are discarded.
- Field ranges and wrap:
  - year 0..99: 99+1 -> 0, 0-1 -> 99.
  - mon 1..12: 12+1 -> 1, 1-1 -> 12.
  - hour 0..23 and min 0..59: wrap the same way.
  - day 1..dim: dim+1 -> 1, 1-1 -> dim.
- dim (days in month) is computed from set_mon and set_year:
  - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - Month 2: 29 when set_year[1:0]==0, else 28 (year 0 = 2000, a leap year).
- Day clamp: any change to set_mon or set_year makes set_day = min(set_day, new dim) in the same update cycle.
- Snapshot values outside the legal range are clamped into range when the snapshot is taken: month 0 -> 1, day above dim -> dim.
- Timeout:
  - The counter clears on any event.
  - At TIMEOUT_CYCLES-1 in S_YEAR..S_MIN: go to IDLE with load=0. set_* keep their edited values.
- Reset asserted mid-edit: immediate return to IDLE, no load pulse, outputs at reset values.
- load fires only via COMMIT. No load occurs in any other path.

Test Plan:
- Reset, then cur = 2024-02-29 13:45 and 6 mode presses -> S_YEAR..S_MIN in sequence, then load high for 1 cycle with set_year=24, mon=2, day=29, hour=13, min=45, sec=0; then set_active=0.
- From the same snapshot, in S_YEAR press up once (year 25) -> set_day clamps 29->28; after commit, set_year=25, set_day=28.
- In S_MON with mon=12, up -> 1; down -> 12. In S_MIN with min=59, up -> 0. In S_HOUR with hour=0, down -> 23.
- Snapshot with mon=3, day=31; in S_MON press down -> mon=2, day=29 when year=24 or day=28 when year=23.
- Simultaneous up and down edges in S_DAY -> no change. Mode together with up in S_DAY -> state S_HOUR, day unchanged.
- Two scenarios with small TIMEOUT_CYCLES (e.g. 20):
  - Idle in S_HOUR for 20 cycles -> IDLE, load never asserted.
  - Separately, rst pulse during S_MON -> IDLE immediately, set_mon=1, load=0.
